// File: rtl/uart_tx_framer.sv
// UART transmit framer: 1-entry holding register, start/8 data/stop framing paced by baud_clk.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit(s).
module uart_tx_framer #(
    parameter int   STOP_BITS  = 1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       uart_clk,
    input  logic       rst,
    input  logic       baud_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       sync3_q, sync3_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;
    logic       baud_tick;

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    logic       accept;
    logic       load;
    logic       last_stop;

    // fill_q marks when sync2_q holds a genuine sample; ticks stay disarmed until a real
    // low level is seen, so a baud_clk that is already high at reset release cannot fire.
    always_comb begin
        sync1_d   = baud_clk;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        fill_d    = {fill_q[0], 1'b1};
        armed_d   = armed_q | (fill_q[1] & ~sync2_q);
        baud_tick = sync2_q & ~sync3_q & armed_q;
    end

    assign accept    = tx_valid & ~hold_full_q;
    assign last_stop = (STOP_BITS == 2) ? stop_cnt_q : 1'b1;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        load       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (baud_tick && hold_full_q) begin
                    load    = 1'b1;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d      = parity_q;
                        state_d    = PARITY;
`else
                        txd_d      = IDLE_LEVEL;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    txd_d      = IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (last_stop) begin
                        // A waiting byte starts immediately: no idle bit between frames.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            txd_d   = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = IDLE_LEVEL;
            end
        endcase

        if (load) begin
            shift_d  = hold_q;
`ifdef UART_TX_PARITY_EN
            parity_d = ^hold_q;
`endif
        end
    end

    // A reload consumes the old hold_q while a same-cycle accept overwrites it.
    always_comb begin
        hold_full_d = (hold_full_q & ~load) | accept;
        hold_d      = accept ? tx_data : hold_q;
    end

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            bit_idx_q   <= 3'd0;
            stop_cnt_q  <= 1'b0;
            txd_q       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            txd_q       <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_ready = ~hold_full_q;
    assign txd      = txd_q;
    assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: dut_a uses one stop bit, dut_b two; line sampled mid-bit
// on the falling edge of baud_clk. Honors UART_TX_PARITY_EN when defined.
module tb_uart_tx_framer;

    logic       uart_clk = 1'b0;
    logic       baud_clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       txd_a, txd_b;
    logic       tx_busy_a, tx_busy_b;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_framer #(.STOP_BITS(1), .IDLE_LEVEL(1'b1)) dut_a (
        .uart_clk (uart_clk),
        .rst      (rst),
        .baud_clk (baud_clk),
        .tx_data  (tx_data_a),
        .tx_valid (tx_valid_a),
        .tx_ready (tx_ready_a),
        .txd      (txd_a),
        .tx_busy  (tx_busy_a)
    );

    uart_tx_framer #(.STOP_BITS(2), .IDLE_LEVEL(1'b1)) dut_b (
        .uart_clk (uart_clk),
        .rst      (rst),
        .baud_clk (baud_clk),
        .tx_data  (tx_data_b),
        .tx_valid (tx_valid_b),
        .tx_ready (tx_ready_b),
        .txd      (txd_b),
        .tx_busy  (tx_busy_b)
    );

    always #5 uart_clk = ~uart_clk;

    initial begin
        #3;
        forever #80 baud_clk = ~baud_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic line_of(input bit sel);
        return sel ? txd_b : txd_a;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? tx_busy_b : tx_busy_a;
    endfunction

    function automatic logic ready_of(input bit sel);
        return sel ? tx_ready_b : tx_ready_a;
    endfunction

    task automatic drive(input bit sel, input logic [7:0] b, input logic v);
        if (sel) begin
            tx_data_b  = b;
            tx_valid_b = v;
        end else begin
            tx_data_a  = b;
            tx_valid_a = v;
        end
    endtask

    // keep=1 leaves tx_valid high so the caller can chain the next byte.
    task automatic send(input bit sel, input logic [7:0] b, input bit keep, input string tag);
        int n;
        n = 0;
        @(negedge uart_clk);
        drive(sel, b, 1'b1);
        while (!ready_of(sel) && n < 3000) begin
            @(negedge uart_clk);
            n++;
        end
        check_eq({tag, "_accept"}, ready_of(sel), 1'b1);
        @(posedge uart_clk);
        @(negedge uart_clk);
        if (!keep) drive(sel, b, 1'b0);
        check_eq({tag, "_ready_low"}, ready_of(sel), 1'b0);
    endtask

    task automatic expect_frame(input bit sel, input logic [7:0] b, input logic par,
                                input int nstop, input bit b2b, input string tag);
        int n;
        n = 0;
        if (b2b) begin
            @(negedge baud_clk);
        end else begin
            do begin
                @(negedge baud_clk);
                n++;
            end while (line_of(sel) !== 1'b0 && n < 40);
        end
        check_eq({tag, "_start"}, line_of(sel), 1'b0);
        check_eq({tag, "_busy_start"}, busy_of(sel), 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge baud_clk);
            check_eq($sformatf("%s_d%0d", tag, i), line_of(sel), b[i]);
        end
`ifdef UART_TX_PARITY_EN
        @(negedge baud_clk);
        check_eq({tag, "_par"}, line_of(sel), par);
`else
        if (par !== 1'b0 && par !== 1'b1) $display("note %s: parity unknown", tag);
`endif
        for (int k = 0; k < nstop; k++) begin
            @(negedge baud_clk);
            check_eq($sformatf("%s_stop%0d", tag, k), line_of(sel), 1'b1);
            check_eq($sformatf("%s_busy_stop%0d", tag, k), busy_of(sel), 1'b1);
        end
    endtask

    task automatic idle_check(input bit sel, input string tag);
        @(negedge baud_clk);
        check_eq({tag, "_idle_txd"}, line_of(sel), 1'b1);
        check_eq({tag, "_idle_busy"}, busy_of(sel), 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        repeat (3) @(negedge uart_clk);
        check_eq("rst_txd_a", txd_a, 1'b1);
        check_eq("rst_ready_a", tx_ready_a, 1'b1);
        check_eq("rst_busy_a", tx_busy_a, 1'b0);
        check_eq("rst_txd_b", txd_b, 1'b1);
        check_eq("rst_ready_b", tx_ready_b, 1'b1);
        check_eq("rst_busy_b", tx_busy_b, 1'b0);
        rst = 1'b0;

        // 0xA5: 0,1,0,1,0,0,1,0,1,1 (parity 0)
        fork
            send(1'b0, 8'hA5, 1'b0, "a5");
            expect_frame(1'b0, 8'hA5, 1'b0, 1, 1'b0, "fa5");
        join
        idle_check(1'b0, "a5");

        // 0x07: data 1,1,1,0,0,0,0,0, parity 1
        fork
            send(1'b0, 8'h07, 1'b0, "s07");
            expect_frame(1'b0, 8'h07, 1'b1, 1, 1'b0, "f07");
        join
        idle_check(1'b0, "s07");

        // back-to-back 0x00 then 0xFF with tx_valid held
        fork
            begin
                send(1'b0, 8'h00, 1'b1, "s00");
                send(1'b0, 8'hFF, 1'b0, "sff");
            end
            begin
                expect_frame(1'b0, 8'h00, 1'b0, 1, 1'b0, "f00");
                expect_frame(1'b0, 8'hFF, 1'b0, 1, 1'b1, "fff");
            end
        join
        idle_check(1'b0, "bb");

        // byte offered while holding register full is dropped
        @(posedge baud_clk);
        repeat (5) @(negedge uart_clk);
        fork
            begin
                send(1'b0, 8'h5A, 1'b0, "s5a");
                @(negedge uart_clk);
                check_eq("drop_ready", tx_ready_a, 1'b0);
                drive(1'b0, 8'hEE, 1'b1);
                @(negedge uart_clk);
                drive(1'b0, 8'hEE, 1'b0);
            end
            expect_frame(1'b0, 8'h5A, 1'b0, 1, 1'b0, "f5a");
        join
        idle_check(1'b0, "drop1");
        idle_check(1'b0, "drop2");

        // reset during data bit 3 of 0x3C with 0x99 waiting in the holding register
        send(1'b0, 8'h3C, 1'b0, "s3c");
        send(1'b0, 8'h99, 1'b0, "s99");
        n = 0;
        do begin
            @(negedge baud_clk);
            n++;
        end while (txd_a !== 1'b0 && n < 40);
        check_eq("r3c_start", txd_a, 1'b0);
        @(negedge baud_clk);
        check_eq("r3c_d0", txd_a, 1'b0);
        @(negedge baud_clk);
        check_eq("r3c_d1", txd_a, 1'b0);
        @(negedge baud_clk);
        check_eq("r3c_d2", txd_a, 1'b1);
        @(posedge baud_clk);
        repeat (6) @(negedge uart_clk);
        check_eq("r3c_d3", txd_a, 1'b1);
        check_eq("r3c_busy_pre", tx_busy_a, 1'b1);
        check_eq("r3c_ready_pre", tx_ready_a, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rmid_txd", txd_a, 1'b1);
        check_eq("rmid_ready", tx_ready_a, 1'b1);
        check_eq("rmid_busy", tx_busy_a, 1'b0);
        repeat (2) @(negedge uart_clk);
        rst = 1'b0;
        fork
            send(1'b0, 8'h81, 1'b0, "s81");
            expect_frame(1'b0, 8'h81, 1'b0, 1, 1'b0, "f81");
        join
        idle_check(1'b0, "s81");

        // two stop bits, 0x55 then 0x12 back-to-back
        fork
            begin
                send(1'b1, 8'h55, 1'b1, "s55");
                send(1'b1, 8'h12, 1'b0, "s12");
            end
            begin
                expect_frame(1'b1, 8'h55, 1'b0, 2, 1'b0, "f55");
                expect_frame(1'b1, 8'h12, 1'b0, 2, 1'b1, "f12");
            end
        join
        idle_check(1'b1, "s2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b1, txd level when idle and during stop bits.
REQ-003 SHALL have port uart_clk  input  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port baud_clk  input  1  divided baud clock from the tx divider, sampled as data (never used as a clock).
REQ-006 SHALL have port tx_data  input  8  byte to transmit.
REQ-007 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-008 SHALL have port tx_ready  output  1  holding register empty; byte accepted when tx_valid&&tx_ready.
REQ-009 SHALL have port txd  output  1  serial line output.
REQ-010 SHALL have port tx_busy  output  1  high while a frame is on the line (START..STOP).

Function
REQ-011 SHALL pass baud_clk through a 2-flop synchroniser, then generate a 1-cycle baud_tick on each synchronised 0->1 transition; one bit time = one baud_tick interval.
REQ-012 SHALL hold one byte in a 1-entry holding register: tx_ready=1 when empty; on accept it loads tx_data and tx_ready drops the next cycle.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; all transitions occur only on baud_tick.
REQ-014 IDLE: on baud_tick with holding register full, SHALL move the byte to the shift register, free the holding register in the same cycle, drive txd=0, enter START.
REQ-015 START: on the next baud_tick SHALL drive tx bit 0 and enter DATA with bit index 0.
REQ-016 DATA: SHALL shift LSB first; on each baud_tick advance the index; after bit 7 has been held one bit time, go to PARITY (macro defined) or STOP.
REQ-017 PARITY: SHALL drive even parity (XOR of the 8 data bits) for one bit time, then go to STOP.
REQ-018 STOP: SHALL drive IDLE_LEVEL for STOP_BITS bit times, using a 1-bit stop counter.
REQ-019 At the end of STOP, if the holding register is full, SHALL go directly to START (drive 0) with no idle bit (back-to-back frames); otherwise go to IDLE.
REQ-020 Accept and the end-of-STOP reload in the same cycle: the reload SHALL take the old holding value, and the new byte SHALL be written into the freed register.
REQ-021 tx_busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-022 txd SHALL be registered (glitch-free) and change only in the cycle after baud_tick.
REQ-023 tx_data SHALL be ignored when tx_valid=0 or tx_ready=0.

Reset
REQ-024 On rst=1 asynchronously: FSM=IDLE, txd=IDLE_LEVEL, tx_ready=1, tx_busy=0, holding register empty, synchroniser flops=0, all counters=0.
REQ-025 Reset mid-frame SHALL abort the frame immediately, with no stop bit sent, and discard any held byte.
REQ-026 After rst is released, the first baud_tick SHALL require a fresh synchronised 0->1 transition of baud_clk (no spurious tick from the reset state).

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, the PARITY state is present and the frame has 1+8+1+STOP_BITS bits; when undefined, PARITY is removed and the frame has 1+8+STOP_BITS bits.

Verification
REQ-028 Single byte 0xA5, STOP_BITS=1, no parity -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting one baud_clk period; tx_busy high for 10 bit times.
REQ-029 UART_TX_PARITY_EN defined, byte 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1.
REQ-030 Two bytes 0x00 and 0xFF with tx_valid held high -> second start bit immediately follows the stop bit; tx_ready low between accepts; no idle gap.
REQ-031 STOP_BITS=2, byte 0x55 -> two bit times of txd=1 after bit 7 before IDLE or the next start.
REQ-032 rst asserted during DATA bit 3 of 0x3C -> txd=1, tx_ready=1 and tx_busy=0 in the same cycle; the next byte 0x81 is sent as a complete, correct frame.
REQ-033 tx_valid pulsed while tx_ready=0 -> byte dropped; only the previously accepted byte appears on txd.
